// File: rtl/ps2_cmd_arbiter_pkg.sv
// Shared types and device response codes for the PS/2 command arbiter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    WAIT_ACK,
    DONE
  } ps2_arb_state_t;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_ERROR     = 8'hFC;
  localparam logic [7:0] PS2_RESET_CMD = 8'hFF;

  function automatic logic is_response(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ERROR);
  endfunction

endpackage

// File: rtl/ps2_cmd_arbiter_if.sv
// Requester handshakes, transmitter/receiver strobes and the forwarded byte stream.
interface ps2_cmd_arbiter_if;
  import ps2_pkg::*;

  logic       req0_vld;
  logic [7:0] req0_data;
  logic       req0_ack;
  logic       req0_done;
  logic       req0_err;

  logic       req1_vld;
  logic [7:0] req1_data;
  logic       req1_ack;
  logic       req1_done;
  logic       req1_err;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       rd_vld;
  logic [7:0] rd_data;

  logic       strm_vld;
  logic [7:0] strm_data;
  logic       busy;

  modport master (
    input  req0_vld, req0_data, req1_vld, req1_data, wr_done, rd_vld, rd_data,
    output req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err,
    output wr_en, wr_data, strm_vld, strm_data, busy
  );

  modport slave (
    output req0_vld, req0_data, req1_vld, req1_data, wr_done, rd_vld, rd_data,
    input  req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err,
    input  wr_en, wr_data, strm_vld, strm_data, busy
  );

endinterface

// File: rtl/ps2_cmd_arbiter_timer.sv
// Per-attempt timeout counter; saturates at the limit instead of wrapping.
module ps2_cmd_timer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Held while saturated so a timeout masked by a received byte is taken next cycle.
  assign o_expired = i_enable && !i_clear && (r_count == LAST);

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Round-robin arbiter sharing the PS/2 transmit path between two command requesters.
module ps2_cmd_arbiter
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input logic         clk_sys,
  input logic         rst_n,
  ps2_cmd_arbiter_if.master bus
);

  localparam int RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  ps2_arb_state_t r_state;
  logic [7:0]     r_wr_data;
  logic [RW-1:0]  r_retry;
  logic           r_gnt;
  logic           r_rr;
  logic           r_err_pend;
  logic           r_ack0, r_ack1;
  logic           r_done0, r_done1;
  logic           r_err0, r_err1;
  logic           r_strm_vld;
  logic [7:0]     r_strm_data;

  logic w_expired;
  logic w_pick1;
  logic w_fwd;
  logic w_retry;
  logic w_ack_byte;
  logic w_err_byte;

  ps2_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .i_clear   (r_state == SEND),
    .i_enable  ((r_state == WAIT_TX) || (r_state == WAIT_ACK)),
    .o_expired (w_expired)
  );

  // r_rr names the requester favoured when both are pending.
  assign w_pick1    = bus.req1_vld && (!bus.req0_vld || r_rr);
  assign w_fwd      = bus.rd_vld && !((r_state == WAIT_ACK) && is_response(bus.rd_data));
  assign w_ack_byte = bus.rd_vld && (bus.rd_data == PS2_ACK);
  assign w_err_byte = bus.rd_vld && (bus.rd_data == PS2_ERROR);
  assign w_retry    = ((r_state == WAIT_TX) && !bus.wr_done && !bus.rd_vld && w_expired) ||
                      ((r_state == WAIT_ACK) && (bus.rd_vld ? (bus.rd_data == PS2_RESEND)
                                                            : w_expired));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_data   <= '0;
      r_retry     <= '0;
      r_gnt       <= 1'b0;
      r_rr        <= 1'b0;
      r_err_pend  <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_strm_vld  <= 1'b0;
      r_strm_data <= '0;
    end else begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_strm_vld <= w_fwd;
      if (w_fwd) r_strm_data <= bus.rd_data;

      case (r_state)
        IDLE: begin
          if (bus.req0_vld || bus.req1_vld) begin
            r_gnt      <= w_pick1;
            r_wr_data  <= w_pick1 ? bus.req1_data : bus.req0_data;
            r_ack0     <= !w_pick1;
            r_ack1     <= w_pick1;
            r_retry    <= '0;
            r_err_pend <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: r_state <= WAIT_TX;
        WAIT_TX, WAIT_ACK: begin
          if (w_retry) begin
            if (r_retry < RETRY_LIMIT) begin
              r_retry <= r_retry + 1'b1;
              r_state <= SEND;
            end else begin
              r_err_pend <= 1'b1;
              r_state    <= DONE;
            end
          end else if (r_state == WAIT_TX) begin
            if (bus.wr_done) r_state <= WAIT_ACK;
          end else if (w_ack_byte || w_err_byte) begin
            r_err_pend <= w_err_byte;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done0 <= !r_gnt;
          r_done1 <= r_gnt;
          r_err0  <= !r_gnt && r_err_pend;
          r_err1  <= r_gnt && r_err_pend;
          r_rr    <= !r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.wr_en     = (r_state == SEND);
  assign bus.busy      = (r_state != IDLE);
  assign bus.wr_data   = r_wr_data;
  assign bus.req0_ack  = r_ack0;
  assign bus.req1_ack  = r_ack1;
  assign bus.req0_done = r_done0;
  assign bus.req1_done = r_done1;
  assign bus.req0_err  = r_err0;
  assign bus.req1_err  = r_err1;
  assign bus.strm_vld  = r_strm_vld;
  assign bus.strm_data = r_strm_data;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Scoreboard bench for ps2_cmd_arbiter: a scripted device model answers each
// transmitted command while a monitor checks grants, bytes, completions and stream.
module tb_ps2_cmd_arbiter;
  import ps2_pkg::*;

  localparam int TIMEOUT  = 100;
  localparam int RETRIES  = 3;
  localparam int TX_DELAY = 20;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  ps2_cmd_arbiter_if bus();

  ps2_cmd_arbiter #(.TIMEOUT_CYC(TIMEOUT), .MAX_RETRY(RETRIES)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  int         grantQ[$];
  logic [7:0] wrQ[$];
  logic [1:0] doneQ[$];
  logic [7:0] strmQ[$];
  logic [8:0] scriptQ[$];
  logic [7:0] rxQ[$];

  int         devTx   = -1;
  int         devAck  = -1;
  logic [8:0] devPend = 9'h1FF;

  int         monGrant;
  logic [1:0] monDone;
  logic [1:0] expDoneBits;
  logic [1:0] expErrBits;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got event, expected none at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] outVec();
    return {7'b0, bus.req0_ack, bus.req1_ack, bus.req0_done, bus.req1_done,
            bus.req0_err, bus.req1_err, bus.wr_en, bus.busy, bus.strm_vld,
            bus.wr_data, bus.strm_data};
  endfunction

  task automatic expectCmd(input int id, input logic [7:0] data, input int nWr, input logic err);
    grantQ.push_back(id);
    for (int i = 0; i < nWr; i++) wrQ.push_back(data);
    doneQ.push_back({id[0], err});
  endtask

  // Requester: raise vld, drop it on ack, then wait for the completion pulse.
  task automatic applyStimulus(input int id, input logic [7:0] data);
    int n;
    @(negedge clk_sys);
    if (id == 1) begin bus.req1_data = data; bus.req1_vld = 1'b1; end
    else         begin bus.req0_data = data; bus.req0_vld = 1'b1; end
    n = 0;
    do begin @(negedge clk_sys); n++; end
    while (!((id == 1) ? bus.req1_ack : bus.req0_ack) && n < 300);
    if (id == 1) bus.req1_vld = 1'b0; else bus.req0_vld = 1'b0;
    if (n >= 300) begin
      checkOutput("ack timeout", 32'(n), 32'd0);
      return;
    end
    n = 0;
    do begin @(negedge clk_sys); n++; end
    while (!((id == 1) ? bus.req1_done : bus.req0_done) && n < 2000);
    if (n >= 2000) checkOutput("done timeout", 32'(n), 32'd0);
  endtask

  // Device model: script entry per wr_en; 9'h1FF = silent, 9'h1FE = wr_done only.
  initial begin
    bus.wr_done = 1'b0;
    bus.rd_vld  = 1'b0;
    bus.rd_data = 8'h00;
    forever begin
      @(negedge clk_sys);
      bus.wr_done = 1'b0;
      bus.rd_vld  = 1'b0;
      if (!rst_n) begin
        devTx  = -1;
        devAck = -1;
      end else if (bus.wr_en) begin
        devPend = (scriptQ.size() != 0) ? scriptQ.pop_front() : 9'h1FF;
        devTx   = (devPend == 9'h1FF) ? -1 : TX_DELAY;
        devAck  = -1;
      end else if (devTx > 0) begin
        devTx--;
      end else if (devTx == 0) begin
        bus.wr_done = 1'b1;
        devTx       = -1;
        if (!devPend[8]) devAck = 3;
      end else if (devAck > 0) begin
        devAck--;
      end else if (devAck == 0) begin
        bus.rd_vld  = 1'b1;
        bus.rd_data = devPend[7:0];
        devAck      = -1;
      end else if (rxQ.size() != 0) begin
        bus.rd_vld  = 1'b1;
        bus.rd_data = rxQ.pop_front();
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (bus.req0_ack || bus.req1_ack) begin
        if (grantQ.size() == 0) flagFail("unexpected grant");
        else begin
          monGrant = grantQ.pop_front();
          checkOutput("grant", 32'({bus.req1_ack, bus.req0_ack}), (monGrant == 1) ? 32'd2 : 32'd1);
          checkOutput("ack with wr_en", 32'(bus.wr_en), 32'd1);
        end
      end
      if (bus.wr_en) begin
        if (wrQ.size() == 0) flagFail("unexpected wr_en");
        else checkOutput("wr_data", 32'(bus.wr_data), 32'(wrQ.pop_front()));
      end
      if (bus.req0_done || bus.req1_done) begin
        if (doneQ.size() == 0) flagFail("unexpected done");
        else begin
          monDone     = doneQ.pop_front();
          expDoneBits = monDone[1] ? 2'b10 : 2'b01;
          expErrBits  = monDone[0] ? expDoneBits : 2'b00;
          checkOutput("done/err", 32'({bus.req1_done, bus.req0_done, bus.req1_err, bus.req0_err}),
                      32'({expDoneBits, expErrBits}));
        end
      end else if (bus.req0_err || bus.req1_err) begin
        flagFail("err without done");
      end
      if (bus.strm_vld) begin
        if (strmQ.size() == 0) flagFail("unexpected stream byte");
        else checkOutput("strm_data", 32'(bus.strm_data), 32'(strmQ.pop_front()));
      end
    end
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  int wrT[4];
  int n;

  initial begin
    bus.req0_vld  = 1'b0;
    bus.req0_data = 8'h00;
    bus.req1_vld  = 1'b0;
    bus.req1_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset outputs", outVec(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] round-robin with both requesters held");
    repeat (5) scriptQ.push_back(9'h0FA);
    expectCmd(0, 8'h11, 1, 1'b0);
    expectCmd(1, 8'h21, 1, 1'b0);
    expectCmd(0, 8'h12, 1, 1'b0);
    expectCmd(1, 8'h22, 1, 1'b0);
    expectCmd(0, 8'h13, 1, 1'b0);
    fork
      begin applyStimulus(0, 8'h11); applyStimulus(0, 8'h12); applyStimulus(0, 8'h13); end
      begin applyStimulus(1, 8'h21); applyStimulus(1, 8'h22); end
    join

    $display("[TB] single reset command acknowledged");
    scriptQ.push_back(9'h0FA);
    expectCmd(0, PS2_RESET_CMD, 1, 1'b0);
    applyStimulus(0, PS2_RESET_CMD);

    $display("[TB] three resends then ack");
    scriptQ.push_back(9'h0FE); scriptQ.push_back(9'h0FE);
    scriptQ.push_back(9'h0FE); scriptQ.push_back(9'h0FA);
    expectCmd(1, 8'hF2, 4, 1'b0);
    applyStimulus(1, 8'hF2);

    $display("[TB] four resends exhaust retries");
    repeat (4) scriptQ.push_back(9'h0FE);
    expectCmd(0, 8'hED, 4, 1'b1);
    applyStimulus(0, 8'hED);

    $display("[TB] device error reply");
    scriptQ.push_back(9'h0FC);
    expectCmd(1, 8'hF5, 1, 1'b1);
    applyStimulus(1, 8'hF5);

    $display("[TB] silent device times out");
    repeat (4) scriptQ.push_back(9'h1FF);
    expectCmd(0, 8'hF0, 4, 1'b1);
    fork
      applyStimulus(0, 8'hF0);
      begin
        for (int k = 0; k < 4; k++) begin
          n = 0;
          do begin @(negedge clk_sys); n++; end while (!bus.wr_en && n < 500);
          if (n >= 500) checkOutput("timeout resend missing", 32'(k), 32'd4);
          wrT[k] = cyc;
        end
        for (int k = 1; k < 4; k++)
          checkOutput("resend period", 32'(wrT[k] - wrT[k-1]), 32'(TIMEOUT + 1));
      end
    join

    $display("[TB] stream forwarding around a command");
    scriptQ.push_back(9'h1FE);
    expectCmd(1, 8'hF6, 1, 1'b0);
    strmQ.push_back(8'h08);
    strmQ.push_back(8'h09);
    fork
      applyStimulus(1, 8'hF6);
      begin
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!bus.wr_en && n < 300);
        repeat (30) @(negedge clk_sys);
        rxQ.push_back(8'h08);
        rxQ.push_back(PS2_ACK);
      end
    join
    repeat (2) @(negedge clk_sys);
    rxQ.push_back(8'h09);
    repeat (5) @(negedge clk_sys);

    $display("[TB] reset while waiting for the response");
    scriptQ.push_back(9'h1FE);
    grantQ.push_back(1);
    wrQ.push_back(8'hF4);
    @(negedge clk_sys);
    bus.req1_data = 8'hF4;
    bus.req1_vld  = 1'b1;
    n = 0;
    do begin @(negedge clk_sys); n++; end while (!bus.req1_ack && n < 300);
    bus.req1_vld = 1'b0;
    repeat (30) @(negedge clk_sys);
    checkOutput("busy before reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("outputs at reset", outVec(), 32'd0);
    @(negedge clk_sys);
    checkOutput("outputs held in reset", outVec(), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    scriptQ.push_back(9'h0FA);
    expectCmd(1, 8'hF3, 1, 1'b0);
    applyStimulus(1, 8'hF3);

    repeat (10) @(negedge clk_sys);
    checkOutput("grants left", 32'(grantQ.size()), 32'd0);
    checkOutput("writes left", 32'(wrQ.size()), 32'd0);
    checkOutput("dones left", 32'(doneQ.size()), 32'd0);
    checkOutput("stream left", 32'(strmQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
